// File: rtl/spio_spinnaker_link_param_sender.sv
// SpiNNaker link transmitter: FIFO-buffered packets serialised into NRZ 2-of-7 flits.
// Ack-timeout detection is built only when SPIO_SENDER_TMO_EN is defined.
module spio_spinnaker_link_param_sender #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TMO_CYCLES  = 256
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [71:0] PKT_DATA_IN,
  input  logic        PKT_VLD_IN,
  output logic        PKT_RDY_OUT,
  output logic [6:0]  SL_DATA_2OF7_OUT,
  input  logic        SL_ACK_IN,
  output logic        ACK_ERR_OUT,
  output logic        TMO_ERR_OUT,
  output logic        BUSY_OUT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam logic [6:0] EOP_CODE = 7'b1100000;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SYNC_STAGES < 2 || TMO_CYCLES < 2) begin : g_param_check
    $error("spio_spinnaker_link_param_sender: illegal parameter value");
  end

  function automatic logic [6:0] nib_code(input logic [3:0] nib);
    case (nib)
      4'h0:    nib_code = 7'b0010001;
      4'h1:    nib_code = 7'b0010010;
      4'h2:    nib_code = 7'b0010100;
      4'h3:    nib_code = 7'b0011000;
      4'h4:    nib_code = 7'b0100001;
      4'h5:    nib_code = 7'b0100010;
      4'h6:    nib_code = 7'b0100100;
      4'h7:    nib_code = 7'b0101000;
      4'h8:    nib_code = 7'b1000001;
      4'h9:    nib_code = 7'b1000010;
      4'hA:    nib_code = 7'b1000100;
      4'hB:    nib_code = 7'b1001000;
      4'hC:    nib_code = 7'b0000011;
      4'hD:    nib_code = 7'b0000110;
      4'hE:    nib_code = 7'b0001100;
      default: nib_code = 7'b0001001;
    endcase
  endfunction

  logic [71:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s, ack_chg;
  logic                   ack_ref_q, ack_ref_d;
  logic [SW-1:0]          sup_q, sup_d;
  logic [1:0]             state_q, state_d;
  logic [71:0]            shift_q, shift_d, head;
  logic [4:0]             flits_q, flits_d;
  logic [6:0]             data_q, data_d;
  logic                   out_q, out_d;
  logic                   ack_err_q, ack_err_d;
  logic                   full, push, pop;

  assign ack_s       = sync_q[SYNC_STAGES-1];
  assign ack_chg     = ack_s != ack_ref_q;
  assign full        = cnt_q == CW'(FIFO_DEPTH);
  assign PKT_RDY_OUT = !RESET_IN && !full;
  assign push        = PKT_VLD_IN && PKT_RDY_OUT;
  assign pop         = state_q == ST_LOAD;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    ack_ref_d = ack_ref_q;
    sup_d     = sup_q;
    state_d   = state_q;
    shift_d   = shift_q;
    flits_d   = flits_q;
    data_d    = data_q;
    out_d     = out_q;
    ack_err_d = 1'b0;

    // Just out of reset the synchroniser may still be flushing, so follow it silently.
    if (sup_q != '0) begin
      sup_d     = sup_q - 1'b1;
      ack_ref_d = ack_s;
    end

    case (state_q)
      ST_IDLE: if (cnt_q != '0) state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = head;
        flits_d = head[1] ? 5'd18 : 5'd10;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        data_d  = data_q ^ ((flits_q == '0) ? EOP_CODE : nib_code(shift_q[3:0]));
        out_d   = 1'b1;
        state_d = ST_WAIT;
      end
      default: begin
        if (ack_chg) begin
          ack_ref_d = ack_s;
          out_d     = 1'b0;
          if (flits_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            shift_d = shift_q >> 4;
            flits_d = flits_q - 1'b1;
            state_d = ST_SEND;
          end
        end
      end
    endcase

    // A transition landing in SEND is left for WAIT to consume as the ack.
    if (sup_q == '0 && ack_chg && !out_q && state_q != ST_SEND) begin
      ack_err_d = 1'b1;
      ack_ref_d = ack_s;
    end
  end

  always_ff @(posedge CLK_IN) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], SL_ACK_IN};
    if (push) mem_q[wr_ptr_q] <= PKT_DATA_IN;
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ack_ref_q <= ack_s;
      sup_q     <= SW'(SYNC_STAGES);
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      flits_q   <= '0;
      data_q    <= '0;
      out_q     <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ack_ref_q <= ack_ref_d;
      sup_q     <= sup_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      flits_q   <= flits_d;
      data_q    <= data_d;
      out_q     <= out_d;
      ack_err_q <= ack_err_d;
    end
  end

`ifdef SPIO_SENDER_TMO_EN
  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic          tmo_q, tmo_d;

  assign tmr_inc = tmr_q + 1'b1;

  always_comb begin
    tmr_d = tmr_q;
    tmo_d = 1'b0;
    if (state_q == ST_SEND) begin
      tmr_d = '0;
    end else if (state_q == ST_WAIT) begin
      if (tmr_inc == TW'(TMO_CYCLES)) begin
        tmr_d = '0;
        tmo_d = 1'b1;
      end else begin
        tmr_d = tmr_inc;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end

  assign TMO_ERR_OUT = tmo_q;
`else
  assign TMO_ERR_OUT = 1'b0;
`endif

  assign SL_DATA_2OF7_OUT = data_q;
  assign ACK_ERR_OUT      = ack_err_q;
  assign BUSY_OUT         = (cnt_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_spio_spinnaker_link_param_sender.sv
// Self-checking bench: random packets vs a nibble/code-table model of the link symbol stream.
`timescale 1ns/1ps
module tb_spio_spinnaker_link_param_sender;

  localparam int unsigned DEPTH = 4;
  localparam int          SYNC  = 2;
  localparam int          TMO   = 16;
  localparam logic [6:0]  EOP   = 7'b1100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [71:0] pkt = '0;
  logic        vld = 1'b0;
  logic        rdy;
  logic [6:0]  sl_data;
  logic        ack = 1'b0;
  logic        ack_err, tmo_err, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_err_pulses = 0;
  int tmo_pulses     = 0;
  int push_cyc       = 0;

  logic [6:0] prev_data = '0;
  logic [6:0] sym_q[$];
  logic [6:0] exp_q[$];
  int         sym_cyc[$];
  int         ack_cyc[$];
  logic [6:0] code_tbl [17];

  spio_spinnaker_link_param_sender #(
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC),
    .TMO_CYCLES (TMO)
  ) dut (
    .CLK_IN          (clk),
    .RESET_IN        (rst),
    .PKT_DATA_IN     (pkt),
    .PKT_VLD_IN      (vld),
    .PKT_RDY_OUT     (rdy),
    .SL_DATA_2OF7_OUT(sl_data),
    .SL_ACK_IN       (ack),
    .ACK_ERR_OUT     (ack_err),
    .TMO_ERR_OUT     (tmo_err),
    .BUSY_OUT        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ack_err === 1'b1) ack_err_pulses++;
    if (tmo_err === 1'b1) tmo_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    sym_q.delete(); exp_q.delete(); sym_cyc.delete(); ack_cyc.delete();
  endtask

  // Expected symbol deltas: data nibbles LSB-first (18 if long, else 10), then EOP.
  task automatic model_pkt(input logic [71:0] p);
    int n, idx;
    n = p[1] ? 18 : 10;
    for (int i = 0; i < n; i++) begin
      idx = int'(p[4*i +: 4]);
      exp_q.push_back(code_tbl[idx]);
    end
    exp_q.push_back(EOP);
  endtask

  function automatic logic [71:0] rand_pkt(input bit long_pkt);
    logic [71:0] p;
    p = {8'($urandom()), $urandom(), $urandom()};
    p[1] = long_pkt;
    return p;
  endfunction

  task automatic push_pkt(input logic [71:0] d, output bit ok);
    int w;
    w = 0;
    pkt = d;
    vld = 1'b1;
    while (rdy !== 1'b1 && w < 400) begin tick(1); w++; end
    ok = (rdy === 1'b1);
    tick(1);
    vld = 1'b0;
    push_cyc = cyc;
  endtask

  // Far-end responder: logs each symbol delta, optionally toggles ack dly cycles later.
  task automatic serve(input int n, input int dly, input bit do_ack, output int got);
    int w;
    got = 0;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (sl_data === prev_data && w < 300) begin tick(1); w++; end
      if (sl_data === prev_data) return;
      sym_q.push_back(sl_data ^ prev_data);
      sym_cyc.push_back(cyc);
      prev_data = sl_data;
      got++;
      if (do_ack) begin
        if (dly > 0) tick(dly);
        ack = ~ack;
        ack_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(SYNC + 3);
    n_checks++; if (rdy !== 1'b0)        begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
    n_checks++; if (sl_data !== 7'd0)    begin n_fail++; $display("FAIL reset_data: got %b expected 0000000", sl_data); end
    n_checks++; if (ack_err !== 1'b0)    begin n_fail++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
    n_checks++; if (tmo_err !== 1'b0)    begin n_fail++; $display("FAIL reset_tmo_err: got %b expected 0", tmo_err); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    #1;
    n_checks++; if (rdy !== 1'b1)        begin n_fail++; $display("FAIL reset_rdy_after: got %b expected 1", rdy); end
    tick(1);
    n_checks++; if (busy !== 1'b0 || sl_data !== 7'd0) begin
      n_fail++; $display("FAIL reset_idle_after: busy %b data %b expected 0 / 0000000", busy, sl_data);
    end
    prev_data = '0;
    tick(SYNC + 2);
  endtask

  task automatic test_short_packet();
    logic [71:0] p;
    bit ok;
    int got, e0, t0;
    clear_logs();
    e0 = ack_err_pulses; t0 = tmo_pulses;
    p = 72'h12_3456_7880;
    model_pkt(p);
    push_pkt(p, ok);
    serve(11, 4, 1'b1, got);
    n_checks++; if (!ok)       begin n_fail++; $display("FAIL short_push: rdy never high"); end
    n_checks++; if (got != 11) begin n_fail++; $display("FAIL short_count: got %0d symbols expected 11", got); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sym_q.size() || sym_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL short_sym[%0d]: got %b expected %b", i, (i < sym_q.size()) ? sym_q[i] : 7'd0, exp_q[i]);
      end
    end
    if (sym_q.size() >= 2) begin
      n_checks++; if (sym_q[0] !== 7'b0010001) begin n_fail++; $display("FAIL short_first_abs: got %b expected 0010001", sym_q[0]); end
      n_checks++; if ((sym_q[0] ^ sym_q[1]) !== 7'b1010000) begin
        n_fail++; $display("FAIL short_second_abs: got %b expected 1010000", sym_q[0] ^ sym_q[1]);
      end
      n_checks++; if (sym_cyc[0] != push_cyc + 3) begin
        n_fail++; $display("FAIL short_latency: got %0d cycles expected 3", sym_cyc[0] - push_cyc);
      end
      n_checks++; if (sym_cyc[1] - ack_cyc[0] != SYNC + 2) begin
        n_fail++; $display("FAIL short_flit_gap: got %0d cycles expected %0d", sym_cyc[1] - ack_cyc[0], SYNC + 2);
      end
    end
    tick(8);
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL short_busy_end: got %b expected 0", busy); end
    n_checks++; if (sl_data !== prev_data) begin n_fail++; $display("FAIL short_extra_sym: got %b expected %b", sl_data, prev_data); end
    n_checks++; if (ack_err_pulses != e0 || tmo_pulses != t0) begin
      n_fail++; $display("FAIL short_err_pulses: got %0d ack / %0d tmo expected 0 / 0", ack_err_pulses - e0, tmo_pulses - t0);
    end
  endtask

  task automatic test_long_packets();
    logic [71:0] p;
    bit ok;
    int got;
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      p = rand_pkt(1'b1);
      model_pkt(p);
      push_pkt(p, ok);
      serve(19, $urandom_range(0, 5), 1'b1, got);
      n_checks++; if (!ok || got != 19) begin
        n_fail++; $display("FAIL long_count[%0d]: got %0d symbols (push ok %0b) expected 19", k, got, ok);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (i >= sym_q.size() || sym_q[i] !== exp_q[i] || $countones(sym_q[i]) != 2) begin
          n_fail++; $display("FAIL long_sym[%0d][%0d]: got %b expected %b", k, i, (i < sym_q.size()) ? sym_q[i] : 7'd0, exp_q[i]);
        end
      end
      tick(6);
      n_checks++; if (sl_data !== prev_data || busy !== 1'b0) begin
        n_fail++; $display("FAIL long_end[%0d]: data %b busy %b expected %b / 0", k, sl_data, busy, prev_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [71:0] p [6];
    bit ok, ok5;
    int got, n1, e0;
    clear_logs();
    e0 = ack_err_pulses;
    for (int i = 0; i < 6; i++) begin
      p[i] = rand_pkt(1'($urandom()));
      model_pkt(p[i]);
    end
    n1 = p[0][1] ? 19 : 11;
    for (int i = 0; i < 4; i++) begin
      push_pkt(p[i], ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_push[%0d]: rdy never high", i); end
    end
    // The head packet already sits in the shift register, so the FIFO fills on the 5th push.
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy_4: got %b expected 1", rdy); end
    push_pkt(p[4], ok);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_rdy_full: got %b expected 0", rdy); end
    tick(3);
    n_checks++; if (rdy !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stall: rdy %b busy %b expected 0 / 1", rdy, busy);
    end
    fork
      push_pkt(p[5], ok5);
      serve(exp_q.size(), $urandom_range(0, 3), 1'b1, got);
    join
    n_checks++; if (!ok5) begin n_fail++; $display("FAIL b2b_push5: rdy never rose"); end
    n_checks++; if (got != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sym_q.size() || sym_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_sym[%0d]: got %b expected %b", i, (i < sym_q.size()) ? sym_q[i] : 7'd0, exp_q[i]);
      end
    end
    if (ack_cyc.size() >= n1 && sym_cyc.size() > n1) begin
      n_checks++; if (push_cyc != ack_cyc[n1-1] + SYNC + 4) begin
        n_fail++; $display("FAIL b2b_rdy_rise: push at +%0d expected +%0d after EOP ack", push_cyc - ack_cyc[n1-1], SYNC + 4);
      end
      n_checks++; if (sym_cyc[n1] - ack_cyc[n1-1] != SYNC + 4) begin
        n_fail++; $display("FAIL b2b_pkt_gap: got %0d expected %0d", sym_cyc[n1] - ack_cyc[n1-1], SYNC + 4);
      end
    end
    tick(8);
    n_checks++; if (busy !== 1'b0 || ack_err_pulses != e0) begin
      n_fail++; $display("FAIL b2b_end: busy %b ack_err %0d expected 0 / 0", busy, ack_err_pulses - e0);
    end
  endtask

  task automatic test_spurious_ack();
    logic [6:0] d0;
    int e0;
    for (int r = 0; r < 2; r++) begin
      tick(SYNC + 2 + int'($urandom_range(0, 3)));
      d0 = sl_data;
      e0 = ack_err_pulses;
      ack = ~ack;
      for (int k = 1; k <= SYNC + 3; k++) begin
        tick(1);
        n_checks++;
        if (ack_err !== (k == SYNC + 1)) begin
          n_fail++; $display("FAIL spurious_pulse[%0d] at +%0d: got %b expected %b", r, k, ack_err, k == SYNC + 1);
        end
      end
      n_checks++; if (sl_data !== d0 || ack_err_pulses - e0 != 1) begin
        n_fail++; $display("FAIL spurious_effect[%0d]: data %b pulses %0d expected %b / 1", r, sl_data, ack_err_pulses - e0, d0);
      end
    end
  endtask

  task automatic test_timeout();
    logic [71:0] p;
    bit ok;
    int got, got2, s;
    int pulses[$];
    clear_logs();
    p = rand_pkt(1'b0);
    model_pkt(p);
    push_pkt(p, ok);
    serve(1, 0, 1'b0, got);
    n_checks++; if (!ok || got != 1) begin n_fail++; $display("FAIL tmo_first_sym: got %0d expected 1", got); end
    s = (sym_cyc.size() > 0) ? sym_cyc[0] : cyc;
    for (int i = 0; i < 2 * TMO + 4; i++) begin
      tick(1);
      if (tmo_err === 1'b1) pulses.push_back(cyc);
    end
`ifdef SPIO_SENDER_TMO_EN
    n_checks++; if (pulses.size() != 2) begin n_fail++; $display("FAIL tmo_pulse_count: got %0d expected 2", pulses.size()); end
    if (pulses.size() == 2) begin
      n_checks++; if (pulses[0] != s + TMO || pulses[1] != s + 2 * TMO) begin
        n_fail++; $display("FAIL tmo_pulse_time: got +%0d,+%0d expected +%0d,+%0d", pulses[0] - s, pulses[1] - s, TMO, 2 * TMO);
      end
    end
`else
    n_checks++; if (pulses.size() != 0) begin n_fail++; $display("FAIL tmo_disabled: got %0d pulses expected 0", pulses.size()); end
`endif
    n_checks++; if (sl_data !== prev_data) begin n_fail++; $display("FAIL tmo_no_resend: got %b expected %b", sl_data, prev_data); end
    ack = ~ack;
    ack_cyc.push_back(cyc);
    serve(10, 1, 1'b1, got2);
    n_checks++; if (got2 != 10) begin n_fail++; $display("FAIL tmo_resume_count: got %0d expected 10", got2); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sym_q.size() || sym_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL tmo_sym[%0d]: got %b expected %b", i, (i < sym_q.size()) ? sym_q[i] : 7'd0, exp_q[i]);
      end
    end
    tick(6);
  endtask

  task automatic test_mid_reset();
    logic [71:0] p0, p1, p2;
    bit ok0, ok1, ok2;
    int got, e0;
    clear_logs();
    p0 = rand_pkt(1'b1);
    p1 = rand_pkt(1'($urandom()));
    push_pkt(p0, ok0);
    push_pkt(p1, ok1);
    serve(4, 1, 1'b1, got);
    serve(1, 0, 1'b0, got);
    n_checks++; if (!ok0 || !ok1 || sym_q.size() != 5) begin
      n_fail++; $display("FAIL mid_setup: got %0d symbols expected 5", sym_q.size());
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    e0 = ack_err_pulses;
    n_checks++; if (sl_data !== 7'd0) begin n_fail++; $display("FAIL mid_data: got %b expected 0000000", sl_data); end
    n_checks++; if (busy !== 1'b0 || rdy !== 1'b1) begin
      n_fail++; $display("FAIL mid_fifo_empty: busy %b rdy %b expected 0 / 1", busy, rdy);
    end
    prev_data = '0;
    tick(SYNC + 4);
    n_checks++; if (sl_data !== 7'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_stays_idle: data %b busy %b expected 0000000 / 0", sl_data, busy);
    end
    clear_logs();
    p2 = rand_pkt(1'($urandom()));
    model_pkt(p2);
    push_pkt(p2, ok2);
    serve(exp_q.size(), 2, 1'b1, got);
    n_checks++; if (!ok2 || got != exp_q.size()) begin
      n_fail++; $display("FAIL mid_new_count: got %0d expected %0d", got, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sym_q.size() || sym_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL mid_new_sym[%0d]: got %b expected %b", i, (i < sym_q.size()) ? sym_q[i] : 7'd0, exp_q[i]);
      end
    end
    tick(6);
    n_checks++; if (ack_err_pulses != e0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_end: ack_err %0d busy %b expected 0 / 0", ack_err_pulses - e0, busy);
    end
  endtask

  initial begin
    code_tbl = '{7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
                 7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
                 7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
                 7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001,
                 7'b1100000};
    tick(1);
    test_reset();
    test_short_packet();
    test_long_packets();
    test_back_to_back();
    test_spurious_ack();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
